// File: rtl/osc_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : osc_bank_pkg                                                  |
// | Description : Shared FSM state encoding and default parameter constants    |
// |               for the oscillator bank sampler.                              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package osc_bank_pkg;

  localparam int c_N_OSC   = 16;
  localparam int c_CNT_W   = 16;
  localparam int c_WIN_CYC = 10;
  localparam int c_DEPTH   = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_GATE  = 3'd2,
    ST_SUM   = 3'd3,
    ST_WRITE = 3'd4,
    ST_FULL  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/osc_sum_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : osc_sum_tree                                                  |
// | Description : Combinational unsigned sum of N_OSC packed channel counts.    |
// |               Output is wide enough that the sum can never overflow.       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module osc_sum_tree #(
  parameter int N_OSC = 16,
  parameter int CNT_W = 16,
  parameter int MEM_W = 20
) (
  input  logic [N_OSC*CNT_W-1:0] i_counts,
  output logic [MEM_W-1:0]       o_sum
);

  logic [MEM_W-1:0] w_chan [N_OSC];
  logic [MEM_W-1:0] w_acc;

  for (genvar gi = 0; gi < N_OSC; gi++) begin : g_chan
    assign w_chan[gi] = MEM_W'(i_counts[gi*CNT_W +: CNT_W]);
  end

  // Accumulate the zero-extended channels; the synthesiser balances the chain
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < N_OSC; i++) begin
      w_acc = w_acc + w_chan[i];
    end
  end

  assign o_sum = w_acc;

endmodule
`default_nettype wire

// File: rtl/osc_bank_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : osc_bank_sampler                                              |
// | Description : Gates a bank of external oscillator counters for WIN_CYC     |
// |               cycles, sums all channels and stores one sample per window   |
// |               in a single-port buffer until DEPTH samples are captured.    |
// |               Define OSC_BANK_STATS_EN to enable MIN/MAX run statistics.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module osc_bank_sampler
  import osc_bank_pkg::*;
#(
  parameter  int N_OSC   = c_N_OSC,
  parameter  int CNT_W   = c_CNT_W,
  parameter  int WIN_CYC = c_WIN_CYC,
  parameter  int DEPTH   = c_DEPTH,
  localparam int MEM_W   = CNT_W + $clog2(N_OSC),
  localparam int ADR_W   = $clog2(DEPTH)
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic                   STOP,
  input  logic [N_OSC*CNT_W-1:0] COUNTS,
  output logic                   CNT_CLR,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [ADR_W:0]         SAMPLES,
  input  logic                   RD_EN,
  input  logic [ADR_W-1:0]       RD_ADDR,
  output logic [MEM_W-1:0]       RD_DATA,
  output logic                   RD_VALID,
  output logic [MEM_W-1:0]       MIN_SAMPLE,
  output logic [MEM_W-1:0]       MAX_SAMPLE
);

  localparam int WIN_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;

  state_t                   r_state;
  logic                     r_cnt_clr;
  logic                     r_busy;
  logic                     r_done;
  logic [ADR_W:0]           r_samples;
  logic [ADR_W-1:0]         r_wptr;
  logic [WIN_W-1:0]         r_win;
  logic [N_OSC*CNT_W-1:0]   r_counts;
  logic [MEM_W-1:0]         r_sum;
  logic [MEM_W-1:0]         r_mem [DEPTH];
  logic [MEM_W-1:0]         r_rd_data;
  logic                     r_rd_valid;

  logic [MEM_W-1:0]         w_sum;
  logic                     w_start_go;
  logic                     w_mem_we;
  logic [ADR_W-1:0]         w_mem_addr;

  osc_sum_tree #(
    .N_OSC (N_OSC),
    .CNT_W (CNT_W),
    .MEM_W (MEM_W)
  ) u_sum_tree (
    .i_counts (r_counts),
    .o_sum    (w_sum)
  );

  // A new run is accepted only from a resting state; STOP in the same cycle vetoes it
  assign w_start_go = ((r_state == ST_IDLE) || (r_state == ST_FULL)) && START && !STOP;
  // An abort during WRITE discards the pending sample
  assign w_mem_we   = (r_state == ST_WRITE) && !STOP;
  // One shared RAM port: the writer owns it while busy, the reader otherwise
  assign w_mem_addr = r_busy ? r_wptr : RD_ADDR;

  // Capture sequencer: CLEAR -> GATE x WIN_CYC -> SUM -> WRITE per sample
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_cnt_clr <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_samples <= '0;
      r_wptr    <= '0;
      r_win     <= '0;
      r_counts  <= '0;
      r_sum     <= '0;
    end else begin
      r_cnt_clr <= 1'b0;
      if (STOP && r_busy) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_FULL: begin
            if (w_start_go) begin
              r_state   <= ST_CLEAR;
              r_cnt_clr <= 1'b1;
              r_busy    <= 1'b1;
              r_done    <= 1'b0;
              r_samples <= '0;
              r_wptr    <= '0;
            end
          end
          ST_CLEAR: begin
            r_win   <= '0;
            r_state <= ST_GATE;
          end
          ST_GATE: begin
            if (r_win == WIN_W'(WIN_CYC - 1)) begin
              r_counts <= COUNTS;
              r_state  <= ST_SUM;
            end else begin
              r_win <= r_win + WIN_W'(1);
            end
          end
          ST_SUM: begin
            r_sum   <= w_sum;
            r_state <= ST_WRITE;
          end
          ST_WRITE: begin
            r_wptr    <= r_wptr + ADR_W'(1);
            r_samples <= r_samples + (ADR_W+1)'(1);
            if (r_samples == (ADR_W+1)'(DEPTH - 1)) begin
              r_state <= ST_FULL;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state   <= ST_CLEAR;
              r_cnt_clr <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sample buffer write port (contents are not reset)
  always_ff @(posedge CLOCK) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= r_sum;
    end
  end

  // Registered read; RD_DATA holds its last value when a read is refused
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      if (RD_EN && !r_busy) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= r_mem[w_mem_addr];
      end
    end
  end

`ifdef OSC_BANK_STATS_EN
  logic [MEM_W-1:0] r_min;
  logic [MEM_W-1:0] r_max;

  // Running min/max over samples committed in the current run
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_start_go) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_mem_we) begin
      if (r_sum < r_min) r_min <= r_sum;
      if (r_sum > r_max) r_max <= r_sum;
    end
  end

  assign MIN_SAMPLE = r_min;
  assign MAX_SAMPLE = r_max;
`else
  assign MIN_SAMPLE = '0;
  assign MAX_SAMPLE = '0;
`endif

  assign CNT_CLR  = r_cnt_clr;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign SAMPLES  = r_samples;
  assign RD_DATA  = r_rd_data;
  assign RD_VALID = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_osc_bank_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_osc_bank_sampler                                           |
// | Description : Self-checking bench for osc_bank_sampler at default          |
// |               parameters, with a sample-level reference model.             |
// |               Honours OSC_BANK_STATS_EN for the statistics outputs.        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_osc_bank_sampler;

  localparam int N   = 16;
  localparam int CW  = 16;
  localparam int W   = 10;
  localparam int D   = 1024;
  localparam int MW  = CW + 4;
  localparam int AW  = 10;
  localparam int PER = W + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [N*CW-1:0] counts = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          cnt_clr, busy, done, rd_valid;
  logic [AW:0]   samples;
  logic [MW-1:0] rd_data, min_s, max_s;

  int n_pass = 0;
  int n_total = 0;

  logic [MW-1:0] exp_mem [D];
  int            exp_n = 0;

  osc_bank_sampler dut (
    .CLOCK      (clk),
    .RESET      (rst_n),
    .START      (start),
    .STOP       (stop),
    .COUNTS     (counts),
    .CNT_CLR    (cnt_clr),
    .BUSY       (busy),
    .DONE       (done),
    .SAMPLES    (samples),
    .RD_EN      (rd_en),
    .RD_ADDR    (rd_addr),
    .RD_DATA    (rd_data),
    .RD_VALID   (rd_valid),
    .MIN_SAMPLE (min_s),
    .MAX_SAMPLE (max_s)
  );

  always #5 clk = ~clk;

  // Channel patterns: 0 = all 5, 1 = random, 2 = channel index, 3 = stats list on ch0
  function automatic logic [N*CW-1:0] make_counts(input int mode, input int k);
    logic [N*CW-1:0] v;
    int sv [4] = '{50, 30, 70, 40};
    v = '0;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       v[i*CW +: CW] = CW'(5);
        1:       v[i*CW +: CW] = CW'($urandom);
        2:       v[i*CW +: CW] = CW'(i);
        default: v[i*CW +: CW] = (i == 0) ? CW'((k < 4) ? sv[k] : 99) : '0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [MW-1:0] sum_of(input logic [N*CW-1:0] c);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(c[i*CW +: CW]);
    return MW'(s);
  endfunction

  function automatic logic [MW-1:0] exp_min();
    logic [MW-1:0] m;
`ifdef OSC_BANK_STATS_EN
    m = '1;
    for (int i = 0; i < exp_n; i++) if (exp_mem[i] < m) m = exp_mem[i];
`else
    m = '0;
`endif
    return m;
  endfunction

  function automatic logic [MW-1:0] exp_max();
    logic [MW-1:0] m;
    m = '0;
`ifdef OSC_BANK_STATS_EN
    for (int i = 0; i < exp_n; i++) if (exp_mem[i] > m) m = exp_mem[i];
`endif
    return m;
  endfunction

  function automatic logic [MW-1:0] rst_min();
`ifdef OSC_BANK_STATS_EN
    return '1;
`else
    return '0;
`endif
  endfunction

  task automatic do_read(input int addr, output logic v, output logic [MW-1:0] d);
    @(negedge clk);
    rd_en = 1'b1;
    rd_addr = AW'(addr);
    @(negedge clk);
    rd_en = 1'b0;
    v = rd_valid;
    d = rd_data;
  endtask

  // Starts a run and plays counters per window; a window is committed to the
  // model once the next window starts (or the run completes). stop_clr = k
  // aborts 3 cycles into the k-th window (START raised alongside STOP).
  task automatic run_samples(input int mode, input int stop_clr, input int poke_start,
                             output int cyc_done, output int spacing_err, output int clr_seen);
    logic [MW-1:0] pend;
    bit pend_v;
    int last_clr, cyc, stop_at;
    exp_n = 0; pend_v = 0; pend = '0; last_clr = -1; cyc = 0; stop_at = -1;
    spacing_err = 0; clr_seen = 0; cyc_done = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc < D*PER + 50) begin
      if (done) begin cyc_done = cyc; break; end
      if (cnt_clr) begin
        if (pend_v && exp_n < D) begin exp_mem[exp_n] = pend; exp_n++; end
        if (last_clr >= 0 && cyc - last_clr != PER) spacing_err++;
        last_clr = cyc;
        clr_seen++;
        counts = make_counts(mode, clr_seen - 1);
        pend = sum_of(counts);
        pend_v = 1;
        if (clr_seen == stop_clr) stop_at = cyc + 3;
      end
      if (cyc == stop_at) begin
        stop = 1'b1; start = 1'b1;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        pend_v = 0;
        cyc_done = cyc + 1;
        break;
      end
      start = (cyc == poke_start);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (done && pend_v && exp_n < D) begin exp_mem[exp_n] = pend; exp_n++; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_total++; if (samples !== '0) $display("FAIL reset_samples got=%0d exp=0", samples); else n_pass++;
    n_total++; if (cnt_clr !== 1'b1) $display("FAIL reset_cnt_clr got=%b exp=1", cnt_clr); else n_pass++;
    n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else n_pass++;
    n_total++; if (rd_data !== '0) $display("FAIL reset_rd_data got=%0d exp=0", rd_data); else n_pass++;
    n_total++; if (min_s !== rst_min()) $display("FAIL reset_min got=%0h exp=%0h", min_s, rst_min()); else n_pass++;
    n_total++; if (max_s !== '0) $display("FAIL reset_max got=%0h exp=0", max_s); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (busy !== 1'b0 || cnt_clr !== 1'b0) $display("FAIL idle_after_reset busy=%b cnt_clr=%b exp=0/0", busy, cnt_clr); else n_pass++;
  endtask

  task automatic test_full_const();
    int cd, se, cs;
    logic v;
    logic [MW-1:0] d;
    int a;
    run_samples(0, -1, -1, cd, se, cs);
    n_total++; if (cd !== D*PER) $display("FAIL const_done_latency got=%0d exp=%0d", cd, D*PER); else n_pass++;
    n_total++; if (samples !== (AW+1)'(D)) $display("FAIL const_samples got=%0d exp=%0d", samples, D); else n_pass++;
    n_total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL const_flags done=%b busy=%b exp=1/0", done, busy); else n_pass++;
    n_total++; if (se !== 0 || cs !== D) $display("FAIL const_cnt_clr spacing_err=%0d pulses=%0d exp=0/%0d", se, cs, D); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      a = (k == 0) ? 0 : (k == 1) ? D-1 : int'($urandom_range(D-1, 0));
      do_read(a, v, d);
      n_total++; if (v !== 1'b1 || d !== MW'(80)) $display("FAIL const_read[%0d] valid=%b data=%0d exp=1/80", a, v, d); else n_pass++;
    end
    n_total++; if (min_s !== exp_min() || max_s !== exp_max()) $display("FAIL const_stats min=%0d max=%0d exp=%0d/%0d", min_s, max_s, exp_min(), exp_max()); else n_pass++;
  endtask

  task automatic test_read_busy();
    logic v;
    logic [MW-1:0] d;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_total++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL restart_flags done=%b busy=%b exp=0/1", done, busy); else n_pass++;
    repeat (3) @(negedge clk);
    do_read(5, v, d);
    n_total++; if (v !== 1'b0 || d !== MW'(80)) $display("FAIL read_busy valid=%b data=%0d exp=0/80", v, d); else n_pass++;
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    n_total++; if (busy !== 1'b0 || done !== 1'b0 || samples !== '0) $display("FAIL early_stop busy=%b done=%b samples=%0d exp=0/0/0", busy, done, samples); else n_pass++;
    do_read(3, v, d);
    n_total++; if (v !== 1'b1 || d !== MW'(80)) $display("FAIL read_after_stop valid=%b data=%0d exp=1/80", v, d); else n_pass++;
  endtask

  task automatic test_stop_gate();
    int cd, se, cs;
    logic v;
    logic [MW-1:0] d;
    run_samples(2, 3, -1, cd, se, cs);
    n_total++; if (cd < 0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL stop_flags cyc=%0d busy=%b done=%b exp=0/0", cd, busy, done); else n_pass++;
    n_total++; if (samples !== (AW+1)'(2)) $display("FAIL stop_samples got=%0d exp=2", samples); else n_pass++;
    do_read(1, v, d);
    n_total++; if (v !== 1'b1 || d !== exp_mem[1] || d !== MW'(120)) $display("FAIL stop_read1 valid=%b data=%0d exp=1/120", v, d); else n_pass++;
    do_read(2, v, d);
    n_total++; if (v !== 1'b1 || d !== MW'(80)) $display("FAIL stale_read2 valid=%b data=%0d exp=1/80", v, d); else n_pass++;
  endtask

  task automatic test_stats();
    int cd, se, cs;
    logic v;
    logic [MW-1:0] d;
    run_samples(3, 5, -1, cd, se, cs);
    n_total++; if (samples !== (AW+1)'(4)) $display("FAIL stats_samples got=%0d exp=4", samples); else n_pass++;
    n_total++; if (min_s !== exp_min()) $display("FAIL stats_min got=%0d exp=%0d", min_s, exp_min()); else n_pass++;
    n_total++; if (max_s !== exp_max()) $display("FAIL stats_max got=%0d exp=%0d", max_s, exp_max()); else n_pass++;
    do_read(2, v, d);
    n_total++; if (v !== 1'b1 || d !== MW'(70)) $display("FAIL stats_read2 valid=%b data=%0d exp=1/70", v, d); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    int k, cd, se, cs;
    logic v;
    logic [MW-1:0] d;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!cnt_clr && k < 20) begin @(negedge clk); k++; end
    n_total++; if (k >= 20) $display("FAIL mid_write_no_clear got=timeout exp=cnt_clr"); else n_pass++;
    repeat (PER - 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0 || done !== 1'b0 || samples !== '0 || cnt_clr !== 1'b1) $display("FAIL async_reset_ctrl busy=%b done=%b samples=%0d clr=%b exp=0/0/0/1", busy, done, samples, cnt_clr); else n_pass++;
    n_total++; if (rd_valid !== 1'b0 || rd_data !== '0 || min_s !== rst_min() || max_s !== '0) $display("FAIL async_reset_data valid=%b data=%0d min=%0h max=%0h", rd_valid, rd_data, min_s, max_s); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    run_samples(1, 3, -1, cd, se, cs);
    n_total++; if (samples !== (AW+1)'(2) || busy !== 1'b0) $display("FAIL post_reset_run samples=%0d busy=%b exp=2/0", samples, busy); else n_pass++;
    for (int a = 0; a < 2; a++) begin
      do_read(a, v, d);
      n_total++; if (v !== 1'b1 || d !== exp_mem[a]) $display("FAIL post_reset_read[%0d] valid=%b data=%0d exp=1/%0d", a, v, d, exp_mem[a]); else n_pass++;
    end
  endtask

  task automatic test_full_random();
    int cd, se, cs;
    logic v;
    logic [MW-1:0] d;
    run_samples(1, -1, 3*PER + 1, cd, se, cs);
    n_total++; if (cd !== D*PER) $display("FAIL rand_done_latency got=%0d exp=%0d", cd, D*PER); else n_pass++;
    n_total++; if (samples !== (AW+1)'(D) || se !== 0) $display("FAIL rand_samples got=%0d spacing_err=%0d exp=%0d/0", samples, se, D); else n_pass++;
    n_total++; if (min_s !== exp_min() || max_s !== exp_max()) $display("FAIL rand_stats min=%0d max=%0d exp=%0d/%0d", min_s, max_s, exp_min(), exp_max()); else n_pass++;
    for (int a = 0; a < D; a++) begin
      do_read(a, v, d);
      n_total++; if (v !== 1'b1 || d !== exp_mem[a]) $display("FAIL rand_read[%0d] valid=%b data=%0d exp=1/%0d", a, v, d, exp_mem[a]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full_const();
    test_read_busy();
    test_stop_gate();
    test_stats();
    test_reset_mid_write();
    test_full_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/osc_bank_sampler.md
OSC_BANK_SAMPLER -- requirements
Module: osc_bank_sampler

Interface
REQ-001 Parameters (name, default, meaning), one per line below; MEM_W, ADR_W derived, not overridable.
- N_OSC, 16, oscillator channel count (>=2).
- CNT_W, 16, per-channel count width.
- WIN_CYC, 10, gate window length in CLOCK cycles (>=1).
- DEPTH, 1024, sample buffer depth (power of 2).
- MEM_W, CNT_W+$clog2(N_OSC), stored sample width.
- ADR_W, $clog2(DEPTH), buffer address width.
REQ-002 Ports (name, direction, width, meaning), one per line below.
- CLOCK  in  1  single clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse starting a capture run.
- STOP  in  1  one-cycle pulse aborting a run.
- COUNTS  in  N_OSC*CNT_W  channel counts, channel i at bits [i*CNT_W +: CNT_W], synchronous to CLOCK.
- CNT_CLR  out  1  clears external oscillator counters.
- BUSY  out  1  run in progress.
- DONE  out  1  buffer full, data readable.
- SAMPLES  out  ADR_W+1  samples stored in last/current run.
- RD_EN  in  1  read request.
- RD_ADDR  in  ADR_W  read address.
- RD_DATA  out  MEM_W  read data.
- RD_VALID  out  1  RD_DATA valid.
- MIN_SAMPLE, MAX_SAMPLE  out  MEM_W  run statistics.

Function
REQ-003 FSM states IDLE, CLEAR, GATE, SUM, WRITE, FULL; one sample costs exactly WIN_CYC+3 cycles.
REQ-004 IDLE/FULL + START -> CLEAR; SAMPLES, write pointer and DONE zeroed on that edge.
REQ-005 CLEAR: CNT_CLR=1 for exactly one cycle, window counter zeroed, then GATE.
REQ-006 GATE: CNT_CLR=0 for WIN_CYC cycles, then SUM; COUNTS captured on last GATE cycle.
REQ-007 SUM: unsigned sum of all N_OSC channels, MEM_W wide, no overflow possible.
REQ-008 WRITE: sum written at write pointer, pointer and SAMPLES increment; next CLEAR, or FULL if SAMPLES reaches DEPTH.
REQ-009 FULL: DONE=1, BUSY=0; stays until START (new run) or reset.
REQ-010 BUSY=1 in CLEAR, GATE, SUM, WRITE; START while BUSY ignored.
REQ-011 STOP while BUSY -> IDLE next cycle; pending sum discarded, SAMPLES keeps completed count, DONE stays 0; STOP and START same cycle: STOP wins.
REQ-012 Read: RD_EN with BUSY=0 -> RD_DATA=buffer[RD_ADDR], RD_VALID=1 one cycle later; RD_EN while BUSY -> RD_VALID=0, RD_DATA holds.
REQ-013 RD_ADDR >= SAMPLES returns stale buffer content; no error flag.

Reset
REQ-014 RESET low: state IDLE, CNT_CLR=1, BUSY=0, DONE=0, SAMPLES=0, RD_VALID=0, RD_DATA=0, MIN_SAMPLE=all ones, MAX_SAMPLE=0; buffer content undefined.
REQ-015 Reset mid-run aborts immediately; first post-reset cycle is IDLE.

Configuration
REQ-016 Macro OSC_BANK_STATS_EN defined: MIN_SAMPLE/MAX_SAMPLE updated in WRITE, re-initialised on START.
REQ-017 OSC_BANK_STATS_EN undefined: MIN_SAMPLE, MAX_SAMPLE tied to 0, no comparator logic.

Structure
REQ-018 Shared package osc_bank_pkg holds FSM state enum and default parameter constants.
REQ-019 Sub-module osc_sum_tree: combinational N_OSC-input adder, MEM_W output; buffer inferred as single-port RAM.

Verification
REQ-020 Defaults, all channels constant 5, START -> 1024 samples of 80, DONE after 1024*13 cycles, SAMPLES=1024.
REQ-021 Channel i = i, DEPTH=4 -> every sample 120, CNT_CLR pulses at 13-cycle spacing.
REQ-022 STOP during 3rd GATE -> IDLE, SAMPLES=2, DONE=0; RD_ADDR=1 returns 2nd sample.
REQ-023 RD_EN while BUSY -> RD_VALID=0; after DONE, RD_ADDR=0 -> RD_VALID=1 next cycle, correct data.
REQ-024 RESET low mid-WRITE -> all outputs at reset values same cycle; subsequent START runs cleanly.
REQ-025 STATS_EN, samples 50,30,70,40 -> MIN_SAMPLE=30, MAX_SAMPLE=70; undefined -> both 0.
